opl2_reg_wr_arbiter: RTL and testbench



---
 rtl/opl2_pkg.sv | 27 ++
 rtl/opl2_reg_wr_arbiter_rr.sv | 33 +++
 rtl/opl2_reg_wr_arbiter.sv | 145 ++++++++++++++
 tb/tb_opl2_reg_wr_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opl2_pkg.sv
// Shared OPL2 register-write types, widths and arbiter state encoding.
package opl2_pkg;

    localparam int REG_FILE_DATA_WIDTH     = 8;
    localparam int OPL2_MIN_WR_GAP_DEFAULT = 4;
    localparam int GAP_CNT_WIDTH           = 8;

    // One write as seen by the register file.
    typedef struct packed {
        logic                           valid;
        logic [REG_FILE_DATA_WIDTH-1:0] address;
        logic [REG_FILE_DATA_WIDTH-1:0] data;
    } opl2_reg_wr_t;

    // One write as offered by a requester.
    typedef struct packed {
        logic [REG_FILE_DATA_WIDTH-1:0] address;
        logic [REG_FILE_DATA_WIDTH-1:0] data;
    } opl2_wr_req_t;

    typedef enum logic [1:0] {
        ST_RESET_HOLD = 2'd0,
        ST_CLEAR      = 2'd1,
        ST_RUN        = 2'd2
    } arb_state_e;

endpackage

// File: rtl/opl2_reg_wr_arbiter_rr.sv
// Combinational round-robin pick: first asserted request after last_grant_i,
// wrapping modulo NUM_REQ. Returns a one-hot grant and its index.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // Walk the requesters starting just past the previous winner.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise paths that skip an assignment infer latches.
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((int'(last_grant_i) + off) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/opl2_reg_wr_arbiter.sv
// Round-robin arbiter sharing the OPL2 register-write path between NUM_REQ
// requesters, with a minimum spacing of MIN_WR_GAP cycles between writes.
// Optional feature macro: OPL2_INIT_CLEAR_EN -- after reset, sweep all 256
// register addresses with data 0x00 before accepting requester traffic.
module opl2_reg_wr_arbiter
    import opl2_pkg::*;
#(
    parameter  int NUM_REQ    = 2,
    parameter  int MIN_WR_GAP = OPL2_MIN_WR_GAP_DEFAULT,
    localparam int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic         [NUM_REQ-1:0] req_valid,
    output logic         [NUM_REQ-1:0] req_ready,
    input  opl2_wr_req_t [NUM_REQ-1:0] req_wr,
    output opl2_reg_wr_t               opl2_reg_wr,
    output logic         [IDX_W-1:0]   grant_id,
    output logic                       busy,
    output logic                       init_done
);

    localparam logic [GAP_CNT_WIDTH-1:0] GAP_RELOAD = GAP_CNT_WIDTH'(MIN_WR_GAP - 1);

    arb_state_e               state_q, state_d;
    logic [GAP_CNT_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0]         last_grant_q, last_grant_d;
    logic [IDX_W-1:0]         grant_id_q, grant_id_d;
    opl2_reg_wr_t             wr_q, wr_d;
`ifdef OPL2_INIT_CLEAR_EN
    logic [8:0]               clr_cnt_q, clr_cnt_d;   // next sweep address; bit 8 = sweep issued
    logic                     clr_issue;
`endif

    logic [NUM_REQ-1:0] rr_grant;
    logic [IDX_W-1:0]   rr_idx;
    logic               accept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (rr_grant),
        .grant_idx_o  (rr_idx)
    );

    // Ready only to the winner, and only when running with the gap expired.
    always_comb begin
        req_ready = '0;
        if (state_q == ST_RUN && gap_cnt_q == '0) begin
            req_ready = rr_grant;
        end
        accept = |(req_valid & req_ready);
    end

    // Next-state: FSM sequencing, pacing counter, grant history, output write.
    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        wr_d         = wr_q;
        wr_d.valid   = 1'b0;            // address/data hold, valid is a single-cycle pulse
        if (gap_cnt_q != '0) begin
            gap_cnt_d = gap_cnt_q - 8'd1;
        end
`ifdef OPL2_INIT_CLEAR_EN
        clr_cnt_d = clr_cnt_q;
        clr_issue = 1'b0;
`endif

        case (state_q)
            ST_RESET_HOLD: begin
`ifdef OPL2_INIT_CLEAR_EN
                clr_issue = 1'b1;       // first sweep write lands in the first CLEAR cycle
                state_d   = ST_CLEAR;
`else
                state_d   = ST_RUN;
`endif
            end
            ST_CLEAR: begin
`ifdef OPL2_INIT_CLEAR_EN
                clr_issue = (gap_cnt_q == '0) && !clr_cnt_q[8];
                if (wr_q.valid && clr_cnt_q[8]) begin
                    state_d = ST_RUN;   // the 0xFF pulse is on the output this cycle
                end
`else
                state_d = ST_RUN;
`endif
            end
            ST_RUN: begin
                if (accept) begin
                    wr_d.valid   = 1'b1;
                    wr_d.address = req_wr[rr_idx].address;
                    wr_d.data    = req_wr[rr_idx].data;
                    last_grant_d = rr_idx;
                    grant_id_d   = rr_idx;
                    gap_cnt_d    = GAP_RELOAD;
                end
            end
            default: state_d = ST_RESET_HOLD;
        endcase

`ifdef OPL2_INIT_CLEAR_EN
        if (clr_issue) begin
            wr_d.valid   = 1'b1;
            wr_d.address = clr_cnt_q[7:0];
            wr_d.data    = '0;
            clr_cnt_d    = clr_cnt_q + 9'd1;
            gap_cnt_d    = GAP_RELOAD;
        end
`endif
    end

    // State register with synchronous reset; reset abandons any gap, sweep or pulse.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q      <= ST_RESET_HOLD;
            gap_cnt_q    <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            grant_id_q   <= '0;
            wr_q         <= '0;
`ifdef OPL2_INIT_CLEAR_EN
            clr_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            wr_q         <= wr_d;
`ifdef OPL2_INIT_CLEAR_EN
            clr_cnt_q    <= clr_cnt_d;
`endif
        end
    end

    assign opl2_reg_wr = wr_q;
    assign grant_id    = grant_id_q;
    assign busy        = (gap_cnt_q != '0) || (state_q == ST_CLEAR);
    assign init_done   = (state_q == ST_RUN);

endmodule

// File: tb/tb_opl2_reg_wr_arbiter.sv
// Directed bench for opl2_reg_wr_arbiter: one instance paced at 4 cycles,
// one at 1 cycle. The init-clear sweep is exercised when OPL2_INIT_CLEAR_EN is set.
module tb_opl2_reg_wr_arbiter;
    import opl2_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic [1:0]         req_valid4, req_ready4, req_valid1, req_ready1;
    opl2_wr_req_t [1:0] req_wr4, req_wr1;
    opl2_reg_wr_t       wr4, wr1;
    logic [0:0]         gid4, gid1;
    logic               busy4, busy1, init4, init1;

    int n_cmp = 0;
    int n_err = 0;

    opl2_reg_wr_arbiter #(.NUM_REQ(2), .MIN_WR_GAP(4)) dut4 (
        .clk(clk), .reset(reset), .req_valid(req_valid4), .req_ready(req_ready4),
        .req_wr(req_wr4), .opl2_reg_wr(wr4), .grant_id(gid4), .busy(busy4), .init_done(init4)
    );

    opl2_reg_wr_arbiter #(.NUM_REQ(2), .MIN_WR_GAP(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_wr(req_wr1), .opl2_reg_wr(wr1), .grant_id(gid1), .busy(busy1), .init_done(init1)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog");
    end

    // Bounded wait until both instances accept traffic with no gap pending.
    task automatic wait_ready();
        int cyc = 0;
        while (!(init4 && init1 && !busy4 && !busy1) && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_cmp++;
        if (!(init4 && init1 && !busy4 && !busy1)) begin
            n_err++;
            $display("FAIL init_wait: init=%b%b busy=%b%b, expected init=11 busy=00 within 3000 cycles",
                     init4, init1, busy4, busy1);
        end
    endtask

    task automatic do_reset();
        req_valid4 = '0; req_valid1 = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        wait_ready();
    endtask

    task automatic test_reset();
        req_wr4 = '0; req_wr1 = '0;
        req_valid4 = 2'b11; req_valid1 = 2'b11;
        reset = 1'b1;
        repeat (3) @(posedge clk); #1;
        n_cmp++; if (wr4 !== '0) begin n_err++; $display("FAIL reset_wr: got %h expected 0", wr4); end
        n_cmp++; if (req_ready4 !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b expected 00", req_ready4); end
        n_cmp++; if (gid4 !== 1'b0) begin n_err++; $display("FAIL reset_grant_id: got %b expected 0", gid4); end
        n_cmp++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy4); end
        n_cmp++; if (init4 !== 1'b0) begin n_err++; $display("FAIL reset_init_done: got %b expected 0", init4); end
        n_cmp++;
        if ({wr1, req_ready1, gid1, busy1, init1} !== 22'h0) begin
            n_err++; $display("FAIL reset_dut1: got %h expected 0", {wr1, req_ready1, gid1, busy1, init1});
        end
        req_valid4 = '0; req_valid1 = '0;
        reset = 1'b0;
        #1;  // RESET_HOLD cycle
        n_cmp++;
        if (init4 !== 1'b0 || wr4.valid !== 1'b0) begin
            n_err++; $display("FAIL hold_cycle: init=%b valid=%b expected 0 0", init4, wr4.valid);
        end
        @(posedge clk); #1;
`ifdef OPL2_INIT_CLEAR_EN
        n_cmp++;
        if (init4 !== 1'b0 || wr4 !== {1'b1, 8'h00, 8'h00} || busy4 !== 1'b1) begin
            n_err++; $display("FAIL first_clear_cycle: init=%b wr=%h busy=%b expected 0 10000 1", init4, wr4, busy4);
        end
        wait_ready();
`else
        n_cmp++;
        if (init4 !== 1'b1 || init1 !== 1'b1 || busy4 !== 1'b0) begin
            n_err++; $display("FAIL init_rise: init=%b%b busy=%b expected 11 0", init4, init1, busy4);
        end
`endif
    endtask

    task automatic test_single_write();
        req_wr4[0] = {8'hA0, 8'h41};
        req_valid4 = 2'b01;
        #1;
        n_cmp++; if (req_ready4 !== 2'b01) begin n_err++; $display("FAIL single_ready: got %b expected 01", req_ready4); end
        @(posedge clk); #1;
        req_valid4 = '0;
        req_wr4[0] = '0;  // output must come from the captured copy
        #1;
        n_cmp++; if (wr4 !== {1'b1, 8'hA0, 8'h41}) begin n_err++; $display("FAIL single_pulse: got %h expected 1a041", wr4); end
        n_cmp++; if (gid4 !== 1'b0) begin n_err++; $display("FAIL single_grant_id: got %b expected 0", gid4); end
        n_cmp++; if (busy4 !== 1'b1) begin n_err++; $display("FAIL single_busy1: got %b expected 1", busy4); end
        for (int k = 2; k <= 4; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (wr4 !== {1'b0, 8'hA0, 8'h41}) begin n_err++; $display("FAIL single_hold k=%0d: got %h expected 0a041", k, wr4); end
            n_cmp++;
            if (busy4 !== (k <= 3)) begin n_err++; $display("FAIL single_busy k=%0d: got %b expected %b", k, busy4, (k <= 3)); end
        end
    endtask

    task automatic test_contention();
        opl2_reg_wr_t exp;
        logic [1:0]   exp_ready;
        int           w;
        do_reset();
        req_wr4[0] = {8'h10, 8'h00};
        req_wr4[1] = {8'h11, 8'h01};
        req_valid4 = 2'b11;
        for (int k = 0; k < 14; k++) begin
            #1;
            exp_ready = (k % 4 == 0) ? (2'b01 << ((k / 4) % 2)) : 2'b00;
            n_cmp++;
            if (req_ready4 !== exp_ready) begin n_err++; $display("FAIL contend_ready k=%0d: got %b expected %b", k, req_ready4, exp_ready); end
            if (k % 4 == 1) begin
                w = ((k - 1) / 4) % 2;
                exp.valid = 1'b1; exp.address = 8'h10 + 8'(w); exp.data = 8'(w);
                n_cmp++;
                if (wr4 !== exp) begin n_err++; $display("FAIL contend_pulse k=%0d: got %h expected %h", k, wr4, exp); end
                n_cmp++;
                if (gid4 !== 1'(w)) begin n_err++; $display("FAIL contend_grant_id k=%0d: got %b expected %0d", k, gid4, w); end
            end else begin
                n_cmp++;
                if (wr4.valid !== 1'b0) begin n_err++; $display("FAIL contend_idle k=%0d: valid=%b expected 0", k, wr4.valid); end
            end
            @(posedge clk); #1;
        end
        req_valid4 = '0;
    endtask

    task automatic test_streaming();
        opl2_reg_wr_t exp;
        do_reset();
        req_valid1 = 2'b10;
        for (int i = 0; i <= 9; i++) begin
            if (i < 8) req_wr1[1] = {8'h20 + 8'(i), 8'h80 + 8'(i)};
            else       req_valid1 = '0;
            #1;
            n_cmp++;
            if (req_ready1 !== ((i < 8) ? 2'b10 : 2'b00)) begin
                n_err++; $display("FAIL stream_ready i=%0d: got %b", i, req_ready1);
            end
            if (i >= 1 && i <= 8) begin
                exp.valid = 1'b1; exp.address = 8'h20 + 8'(i - 1); exp.data = 8'h80 + 8'(i - 1);
                n_cmp++;
                if (wr1 !== exp || gid1 !== 1'b1) begin
                    n_err++; $display("FAIL stream_pulse i=%0d: got %h id %b expected %h id 1", i, wr1, gid1, exp);
                end
            end else begin
                n_cmp++;
                if (wr1.valid !== 1'b0) begin n_err++; $display("FAIL stream_idle i=%0d: valid=%b expected 0", i, wr1.valid); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall_hold();
        logic [1:0] exp_ready;
        int         pulses = 0;
        req_wr4[0] = {8'h30, 8'h55};
        req_valid4 = 2'b01;
        for (int k = 0; k < 9; k++) begin
            if (k == 1) req_wr4[0] = {8'h31, 8'h66};  // next request, held while stalled
            if (k == 5) req_valid4 = '0;
            #1;
            exp_ready = (k == 0 || k == 4) ? 2'b01 : 2'b00;
            n_cmp++;
            if (req_ready4 !== exp_ready) begin n_err++; $display("FAIL stall_ready k=%0d: got %b expected %b", k, req_ready4, exp_ready); end
            if (k == 1) begin
                n_cmp++;
                if (wr4 !== {1'b1, 8'h30, 8'h55}) begin n_err++; $display("FAIL stall_first: got %h expected 13055", wr4); end
            end
            if (k >= 2 && wr4.valid === 1'b1) begin
                pulses++;
                n_cmp++;
                if (wr4 !== {1'b1, 8'h31, 8'h66} || k != 5) begin
                    n_err++; $display("FAIL stall_pulse k=%0d: got %h expected 13166 at k=5", k, wr4);
                end
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (pulses != 1) begin n_err++; $display("FAIL stall_count: got %0d pulses expected 1", pulses); end
    endtask

    task automatic test_mid_gap_reset();
        req_wr4[1] = {8'h40, 8'h77};
        req_valid4 = 2'b10;
        #1;
        n_cmp++; if (req_ready4 !== 2'b10) begin n_err++; $display("FAIL mgr_ready: got %b expected 10", req_ready4); end
        @(posedge clk); #1;
        req_valid4 = '0;
        #1;
        n_cmp++;
        if (wr4.valid !== 1'b1 || gid4 !== 1'b1) begin n_err++; $display("FAIL mgr_pulse: valid=%b id=%b expected 1 1", wr4.valid, gid4); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({wr4, req_ready4, gid4, busy4, init4} !== 22'h0) begin
            n_err++; $display("FAIL mgr_outputs: got %h expected 0", {wr4, req_ready4, gid4, busy4, init4});
        end
        reset = 1'b0;
        @(posedge clk); #1;
        wait_ready();
        req_wr4[0] = {8'h50, 8'h88};
        req_wr4[1] = {8'h51, 8'h99};
        req_valid4 = 2'b11;
        #1;
        n_cmp++; if (req_ready4 !== 2'b01) begin n_err++; $display("FAIL mgr_first_grant: got %b expected 01", req_ready4); end
        @(posedge clk); #1;
        req_valid4 = '0;
        #1;
        n_cmp++;
        if (wr4 !== {1'b1, 8'h50, 8'h88} || gid4 !== 1'b0) begin
            n_err++; $display("FAIL mgr_first_pulse: got %h id %b expected 15088 id 0", wr4, gid4);
        end
    endtask

`ifdef OPL2_INIT_CLEAR_EN
    task automatic test_clear();
        opl2_reg_wr_t exp;
        req_valid1 = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        req_valid4 = 2'b11;  // must be ignored for the whole sweep
        @(posedge clk); #1;  // first CLEAR cycle
        for (int cyc = 0; cyc <= 1021; cyc++) begin
            if (cyc < 1021) begin
                n_cmp++;
                if (req_ready4 !== 2'b00 || init4 !== 1'b0 || gid4 !== 1'b0 || busy4 !== 1'b1) begin
                    n_err++; $display("FAIL clear_ctrl cyc=%0d: ready=%b init=%b id=%b busy=%b expected 00 0 0 1",
                                      cyc, req_ready4, init4, gid4, busy4);
                end
                exp.valid = (cyc % 4 == 0); exp.address = 8'(cyc / 4); exp.data = 8'h00;
                n_cmp++;
                if (wr4 !== exp) begin n_err++; $display("FAIL clear_pulse cyc=%0d: got %h expected %h", cyc, wr4, exp); end
            end else begin
                n_cmp++;
                if (init4 !== 1'b1 || wr4 !== {1'b0, 8'hFF, 8'h00}) begin
                    n_err++; $display("FAIL clear_done: init=%b wr=%h expected 1 0ff00", init4, wr4);
                end
            end
            @(posedge clk); #1;
        end
        req_valid4 = '0;
        do_reset();
    endtask
`endif

    initial begin
        reset = 1'b1;
        req_valid4 = '0; req_valid1 = '0;
        req_wr4 = '0; req_wr1 = '0;
        test_reset();
        test_single_write();
        test_contention();
        test_streaming();
        test_stall_hold();
        test_mid_gap_reset();
`ifdef OPL2_INIT_CLEAR_EN
        test_clear();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
